// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Digit-serial adder/subtractor. Adds two WIDTH-bit operands DIGIT bits per
//   clock using a single DIGIT-wide full-adder slice and a registered carry.
//   Computes A + B + c_in (sub=0) or A + ~B + c_in (sub=1; c_in=1 gives A-B).
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per RUN cycle (must divide WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   command/operands present
//   in_ready   block can accept a command (state IDLE)
//   a, b       operands (unsigned or two's complement)
//   c_in       carry into bit 0
//   sub        0: A+B+c_in, 1: A+~B+c_in
//   out_valid  result available (state DONE)
//   out_ready  consumer accepts the result
//   sum        result, modulo 2^WIDTH
//   c_out      carry out of the MSB
//   overflow   signed overflow (carry into MSB XOR carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NDIG - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_adder: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // B already conditionally inverted
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             c_out_q;
    logic             ovf_q;
    logic [CNTW-1:0]  cnt_q;

    // Shared digit slice. Operands are shifted right each RUN cycle, so the
    // current digit always sits in the low DIGIT bits.
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] s_dig;
    logic             cy;
    logic             msb_cin;

    always_comb begin
        a_dig          = a_q[DIGIT-1:0];
        b_dig          = b_q[DIGIT-1:0];
        {cy, s_dig}    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of this digit; meaningful on the last digit,
        // where that bit is the result MSB.
        msb_cin        = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ s_dig[DIGIT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= c_in;
                        sum_q   <= '0;
                        c_out_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    // Each new digit enters at the top and moves down, so after
                    // NDIG cycles digit k lands at bits [k*DIGIT +: DIGIT].
                    sum_q   <= (sum_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
                    carry_q <= cy;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        c_out_q <= cy;
                        ovf_q   <= msb_cin ^ cy;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder. A main 8-bit/1-bit-digit instance gets
//   directed cases, backpressure, mid-operation reset and random traffic; four
//   auxiliary instances (8/4, 4/1, 4/2, 4/4) run random or exhaustive traffic
//   with random output backpressure. Expected results come from plain integer
//   arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    typedef struct {
        int e;   // {ovf, c_out, sum} packed as sum | c_out<<W | ovf<<(W+1)
        int t;   // cycle count after the accept edge
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic rst_m;
    logic rst_aux;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: integer add with explicit unsigned and signed range checks.
    function automatic int ref_add(input int w, input int av, input int bv,
                                   input int cv, input int sv);
        int m, bb, t, s, co, sa, sb, st, ov;
        m  = 1 << w;
        bb = sv ? (m - 1 - bv) : bv;
        t  = av + bb + cv;
        s  = t % m;
        co = t / m;
        sa = (av >= m / 2) ? av - m : av;
        sb = (bb >= m / 2) ? bb - m : bb;
        st = sa + sb + cv;
        ov = (st < -(m / 2) || st > (m / 2 - 1)) ? 1 : 0;
        return s | (co << w) | (ov << (w + 1));
    endfunction

    function automatic int cfg_w(input int g);
        return (g == 0) ? 8 : 4;
    endfunction

    function automatic int cfg_d(input int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 4;
    endfunction

    // ---------------------------------------------------------------- main DUT
    logic       m_in_valid, m_in_ready, m_c_in, m_sub;
    logic       m_out_valid, m_out_ready, m_c_out, m_ovf;
    logic [7:0] m_a, m_b, m_sum;
    exp_t       mq[$];
    exp_t       m_e;
    logic       m_prev_ov = 1'b0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk      (clk),
        .rst_n    (rst_m),
        .in_valid (m_in_valid),
        .in_ready (m_in_ready),
        .a        (m_a),
        .b        (m_b),
        .c_in     (m_c_in),
        .sub      (m_sub),
        .out_valid(m_out_valid),
        .out_ready(m_out_ready),
        .sum      (m_sum),
        .c_out    (m_c_out),
        .overflow (m_ovf)
    );

    task automatic send_m(input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv);
        int unsigned guard = 0;
        @(negedge clk);
        while (!m_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!m_in_ready) begin
            check("m_accept_timeout", int'(m_in_ready), 1);
            return;
        end
        m_a = av; m_b = bv; m_c_in = cv; m_sub = sv; m_in_valid = 1'b1;
        mq.push_back('{e: ref_add(8, int'(av), int'(bv), int'(cv), int'(sv)), t: cyc + 1});
        @(negedge clk);
        m_in_valid = 1'b0;
    endtask

    task automatic drain_m();
        int unsigned guard = 0;
        while (mq.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("m_drain", mq.size(), 0);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (m_out_valid && !m_prev_ov) begin
            if (mq.size() == 0) check("m_spurious_valid", mq.size(), 1);
            else                check("m_latency", cyc - mq[0].t, 8);
        end
        if (m_out_valid && m_out_ready && mq.size() != 0) begin
            m_e = mq.pop_front();
            check("m_sum",  int'(m_sum),   m_e.e & 8'hFF);
            check("m_cout", int'(m_c_out), (m_e.e >> 8) & 1);
            check("m_ovf",  int'(m_ovf),   (m_e.e >> 9) & 1);
        end
        m_prev_ov = m_out_valid;
    end

    // ----------------------------------------------------------- aux DUTs
    for (genvar g = 0; g < 4; g++) begin : gcfg
        localparam int W  = cfg_w(g);
        localparam int D  = cfg_d(g);
        localparam int NV = (W <= 4) ? 1024 : 300;

        logic         g_in_valid, g_in_ready, g_c_in, g_sub;
        logic         g_out_valid, g_out_ready, g_c_out, g_ovf;
        logic [W-1:0] g_a, g_b, g_sum;
        logic [W-1:0] va, vb;
        logic         vc, vs;
        exp_t         q[$];
        exp_t         ge;
        logic         prev_ov = 1'b0;
        logic         done = 1'b0;
        int unsigned  gd;

        serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk      (clk),
            .rst_n    (rst_aux),
            .in_valid (g_in_valid),
            .in_ready (g_in_ready),
            .a        (g_a),
            .b        (g_b),
            .c_in     (g_c_in),
            .sub      (g_sub),
            .out_valid(g_out_valid),
            .out_ready(g_out_ready),
            .sum      (g_sum),
            .c_out    (g_c_out),
            .overflow (g_ovf)
        );

        always @(negedge clk) g_out_ready = ($urandom_range(0, 3) != 0);

        initial begin
            g_in_valid = 1'b0;
            g_a = '0; g_b = '0; g_c_in = 1'b0; g_sub = 1'b0;
            wait (rst_aux === 1'b1);
            for (int i = 0; i < NV; i++) begin
                if (W > 4) begin
                    if (i == 0) begin
                        va = W'(16); vb = W'(32); vc = 1'b1; vs = 1'b1;
                    end else begin
                        va = W'($urandom); vb = W'($urandom);
                        vc = 1'($urandom); vs = 1'($urandom);
                    end
                end else begin
                    va = W'(i & 15); vb = W'((i >> 4) & 15);
                    vc = 1'((i >> 8) & 1); vs = 1'((i >> 9) & 1);
                end
                repeat ($urandom_range(0, 1)) @(negedge clk);
                @(negedge clk);
                gd = 0;
                while (!g_in_ready && gd < 200) begin
                    @(negedge clk);
                    gd++;
                end
                if (!g_in_ready) begin
                    check($sformatf("w%0dd%0d_accept_timeout", W, D), int'(g_in_ready), 1);
                end else begin
                    g_a = va; g_b = vb; g_c_in = vc; g_sub = vs; g_in_valid = 1'b1;
                    q.push_back('{e: ref_add(W, int'(va), int'(vb), int'(vc), int'(vs)),
                                  t: cyc + 1});
                    @(negedge clk);
                    g_in_valid = 1'b0;
                    g_a = W'($urandom); g_b = W'($urandom);
                end
            end
            gd = 0;
            while (q.size() != 0 && gd < 2000) begin
                @(negedge clk);
                gd++;
            end
            check($sformatf("w%0dd%0d_drain", W, D), q.size(), 0);
            done = 1'b1;
        end

        always begin
            @(negedge clk);
            #1;
            if (g_out_valid && !prev_ov) begin
                if (q.size() == 0) check($sformatf("w%0dd%0d_spurious_valid", W, D), q.size(), 1);
                else               check($sformatf("w%0dd%0d_latency", W, D), cyc - q[0].t, W / D);
            end
            if (g_out_valid && g_out_ready && q.size() != 0) begin
                ge = q.pop_front();
                check($sformatf("w%0dd%0d_sum", W, D),  int'(g_sum),   ge.e & ((1 << W) - 1));
                check($sformatf("w%0dd%0d_cout", W, D), int'(g_c_out), (ge.e >> W) & 1);
                check($sformatf("w%0dd%0d_ovf", W, D),  int'(g_ovf),   (ge.e >> (W + 1)) & 1);
            end
            prev_ov = g_out_valid;
        end
    end

    // ------------------------------------------------------------ main flow
    int          bp_e;
    int unsigned guard;

    initial begin
        rst_m = 1'b0; rst_aux = 1'b0;
        m_in_valid = 1'b0; m_a = '0; m_b = '0; m_c_in = 1'b0; m_sub = 1'b0;
        m_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_m = 1'b1; rst_aux = 1'b1;
        #1;
        check("rst_in_ready",  int'(m_in_ready),  1);
        check("rst_out_valid", int'(m_out_valid), 0);
        check("rst_sum",       int'(m_sum),       0);
        check("rst_cout",      int'(m_c_out),     0);
        check("rst_ovf",       int'(m_ovf),       0);

        // Directed: plain add, unsigned wrap, signed overflow.
        send_m(8'h3C, 8'h05, 1'b0, 1'b0);
        send_m(8'hFF, 8'h01, 1'b0, 1'b0);
        send_m(8'h7F, 8'h01, 1'b0, 1'b0);
        drain_m();

        // Backpressure in DONE while the producer wiggles its inputs.
        m_out_ready = 1'b0;
        send_m(8'h5A, 8'h33, 1'b1, 1'b0);
        bp_e = (mq.size() != 0) ? mq[0].e : 0;
        guard = 0;
        while (!m_out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bp_reach_done", int'(m_out_valid), 1);
        repeat (10) begin
            @(negedge clk);
            m_in_valid = 1'($urandom); m_a = 8'($urandom); m_b = 8'($urandom);
            #1;
            check("bp_sum",       int'(m_sum),       bp_e & 8'hFF);
            check("bp_cout",      int'(m_c_out),     (bp_e >> 8) & 1);
            check("bp_ovf",       int'(m_ovf),       (bp_e >> 9) & 1);
            check("bp_in_ready",  int'(m_in_ready),  0);
            check("bp_out_valid", int'(m_out_valid), 1);
        end
        @(negedge clk);
        m_in_valid = 1'b0;
        m_out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_in_ready",  int'(m_in_ready),  1);
        check("bp_release_out_valid", int'(m_out_valid), 0);
        check("bp_release_sum_held",  int'(m_sum),       bp_e & 8'hFF);
        drain_m();

        // Reset while processing digit 3 of 8; the operation is abandoned.
        send_m(8'hA5, 8'h5A, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_m = 1'b0;
        mq.delete();
        #1;
        check("mid_rst_sum",       int'(m_sum),       0);
        check("mid_rst_cout",      int'(m_c_out),     0);
        check("mid_rst_ovf",       int'(m_ovf),       0);
        check("mid_rst_in_ready",  int'(m_in_ready),  1);
        check("mid_rst_out_valid", int'(m_out_valid), 0);
        repeat (2) @(negedge clk);
        rst_m = 1'b1;
        send_m(8'h12, 8'h34, 1'b1, 1'b0);
        drain_m();

        // Random traffic.
        repeat (200) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_m(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        drain_m();

        guard = 0;
        while (!(gcfg[0].done && gcfg[1].done && gcfg[2].done && gcfg[3].done) &&
               guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        check("aux_done",
              int'(gcfg[0].done && gcfg[1].done && gcfg[2].done && gcfg[3].done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised, multi-cycle successor to the combinational half/full adders. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, holding a registered carry between digits. The block trades latency for area: one DIGIT-wide full-adder slice is reused WIDTH/DIGIT times. Valid/ready handshakes on input and output let it sit between producer and consumer stages in the arithmetic datapath.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
DIGIT, 1, bits processed per RUN cycle; WIDTH % DIGIT == 0 required (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/command present
in_ready  output  1  block can accept a command
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
c_in  input  1  carry into bit 0
sub  input  1  0: A+B+c_in; 1: A+~B+c_in (set c_in=1 for A-B)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  carry out of MSB
overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, overflow=0, digit counter=0, carry reg=0. Asserting reset mid-RUN or in DONE abandons the operation; no result is ever produced for it.
- NDIG = WIDTH/DIGIT. Counter width = clog2(NDIG), minimum 1 bit.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); both are combinational decodes of registered state.
- IDLE: on in_valid && in_ready, capture a, (sub ? ~b : b), c_in into internal registers; clear sum, c_out, overflow; counter=0; go to RUN. Inputs are don't-care after the accept edge.
- RUN, each cycle: digit k=counter; {carry, sum[k*DIGIT +: DIGIT]} = A[k*DIGIT +: DIGIT] + B'[k*DIGIT +: DIGIT] + carry_reg; carry_reg <= carry; counter++.
- On the last digit (counter==NDIG-1): c_out <= final carry; overflow <= carry into bit WIDTH-1 XOR final carry; go to DONE.
- Latency: accept at edge T; out_valid high after edge T+NDIG (NDIG RUN cycles). Throughput: one op per NDIG+2 cycles at best (DONE and IDLE each occupy at least one cycle).
- DONE: sum, c_out, overflow held stable while out_valid=1 and out_ready=0 (backpressure is indefinite). On out_ready high, go to IDLE at next edge; outputs keep their values until the next accept clears them.
- in_valid during RUN/DONE is ignored (in_ready=0); the producer must hold it until accepted.
- out_ready outside DONE has no effect.
- DIGIT==WIDTH degenerates to a single RUN cycle; behaviour otherwise identical.
- Results are arithmetically identical to a combinational WIDTH-bit ripple adder for all inputs; wrap-around is modulo 2^WIDTH with c_out carrying the lost bit.

Test Plan:
- Reset/idle: rst_n low 3 cycles, release -> in_ready=1, out_valid=0, sum=0, c_out=0, overflow=0.
- Basic add (WIDTH=8, DIGIT=1): a=8'h3C, b=8'h05, c_in=0, sub=0 -> out_valid exactly 8 cycles after accept, sum=8'h41, c_out=0, overflow=0.
- Wrap and signed overflow: a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1, overflow=0; a=8'h7F, b=8'h01 -> sum=8'h80, c_out=0, overflow=1.
- Subtract (WIDTH=8, DIGIT=4): a=8'h10, b=8'h20, sub=1, c_in=1 -> out_valid 2 cycles after accept, sum=8'hF0, c_out=0 (borrow), overflow=0.
- Backpressure and ignored input: hold out_ready=0 for 10 cycles in DONE while toggling in_valid/a/b -> sum/c_out/overflow stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-operation: assert rst_n low at RUN digit 3 of 8 -> outputs zero immediately (asynchronous), state IDLE; a new op afterwards completes correctly; plus exhaustive sweep WIDTH=4 (DIGIT=1,2,4) of all a, b, c_in, sub against a reference model.
